west_edge_feeder: RTL
=====================

# west_edge_feeder

Feeds the west edge of the systolic MAC array: buffers row-vectors from upstream in a small FIFO and issues them row by row as `in_w`/`inst_w` streams to the first tile of each row. Kernel-load and execute bursts are wavefront-skewed, one cycle of delay per row. It is the transmitter for the tile-side west interface. Each tile latches its weight on its first `inst[0]` cycle and executes while `inst[1]` is high.

## Interface
- `ROW`, 8: array rows; number of skewed output lanes.
- `BW`, 4: activation/weight width per lane.
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `LEN_BW`, 8: width of the burst-length field.

Ports (reset is `reset`: synchronous, active-high; clock is `clk`):
- `clk`  in  1  clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `wr`  in  1  write strobe; a write is accepted when `wr && !full`.
- `in`  in  ROW*BW  row-vector; lane r is `in[r*BW +: BW]`.
- `full`  out  1  FIFO holds DEPTH entries.
- `empty`  out  1  FIFO holds 0 entries.
- `cmd_valid`  in  1  burst command request.
- `cmd_ready`  out  1  high only in IDLE.
- `cmd_op`  in  1  0 = kernel load (inst 2'b01), 1 = execute (inst 2'b10).
- `cmd_len`  in  LEN_BW  number of vectors to issue.
- `out_w`  out  ROW*BW  lane r goes to the `in_w` input of the row-r tile.
- `inst_w`  out  ROW*2  lane r is `inst_w[r*2 +: 2]`.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse at burst completion.

## Operation
- FIFO: read/write pointers carry an extra wrap bit.
  - `full` and `empty` are registered-state decodes.
  - No write-to-read bypass: an entry written at edge t is poppable from edge t+1.
  - A write while full is dropped with no state change.
  - A simultaneous pop and write while full is still rejected, because `full` is evaluated before the edge.
- FSM states: IDLE, ISSUE, DRAIN.
  - IDLE: when `cmd_valid && cmd_ready`, latch `cmd_op` and `cmd_len` into `op_q`/`rem_q`.
    - If `cmd_len == 0`, go to DRAIN with `cnt = 0`. No pops occur, so `done` pulses the next cycle.
    - Otherwise go to ISSUE.
  - ISSUE: each edge where `rem_q > 0 && !empty`:
    - pop the FIFO head into the stage register `s_d`;
    - set `s_i` from `op_q` (01 or 10);
    - decrement `rem_q`.
  - ISSUE stall: if the FIFO is empty, load a bubble: `s_d = 0`, `s_i = 00`. The bubble is identical in all lanes, so the wavefront stays aligned.
  - ISSUE exit: on the edge that pops the last vector, go to DRAIN with `cnt = ROW-1`.
  - DRAIN: every edge loads a bubble and decrements `cnt`. While `cnt == 0`, `done = 1`; the next edge goes to IDLE.
- Skew: lane r of `{s_d, s_i}` passes through r extra register stages. Lane 0 is `s` directly; lane r is `s` delayed r cycles.
- Commands are never queued: `cmd_valid` outside IDLE is ignored.
- Reset clears the FIFO, FSM, stage register and all skew stages.
- Reset mid-burst: the in-flight wavefront is discarded, and all outputs read zero from the cycle after the reset edge.

## Timing
- Reset values: `out_w = 0`, `inst_w = 0`, `full = 0`, `empty = 1`, `cmd_ready = 1`, `busy = 0`, `done = 0`.
- Issue latency: a vector popped at edge t appears on lane 0 after edge t, and on lane r after edge t+r. Lanes hold the value for exactly one cycle per pop.
- Burst of n with no stalls (command accepted at edge e):
  - pops at edges e+1 … e+n;
  - lane ROW-1 is active after edges e+ROW … e+n+ROW-1;
  - `done` is high in the cycle following edge e+n+ROW-1;
  - `cmd_ready` rises after edge e+n+ROW.
- Throughput: one vector per cycle while the FIFO is non-empty. Back-to-back bursts have a minimum gap of ROW cycles (DRAIN plus the done cycle).
- A concurrent write and pop keeps occupancy unchanged.

## Test plan
- Reset/idle: assert reset for 2 cycles mid-stream. Expect every output at its reset value, `empty = 1`, and the FIFO contents discarded.
- Load burst (ROW=8): write 3 vectors with lane r = r+1, then issue command op=0, len=3 accepted at edge e.
  - Lane 0 shows `inst 01` with values 1 for edges e+1..e+3.
  - Lane 7 shows `inst 01` with values 8 for edges e+8..e+10.
  - `done` is high after edge e+10; `cmd_ready` rises after e+11.
- Stall: execute len=4 with only 2 vectors written, then 2 more written 5 cycles later. Every lane shows an identical 00 bubble gap, and `done` occurs ROW-1 cycles after the 4th pop.
- FIFO boundary: write 17 vectors with DEPTH=16.
  - `full` rises after the 16th write, and the 17th is dropped.
  - Issue len=16: `empty` rises after the 16th pop, and the popped data matches write order.
- Zero length: command len=0. `busy` lasts 1 cycle, `done` pulses once, no pops, `inst_w` stays 0.
- Reset mid-burst: assert reset during DRAIN of a len=5 execute. No `done` pulse, `inst_w` returns to 0 next cycle, and a new load command is accepted immediately afterward.

Source files
------------

// File: rtl/west_edge_feeder.sv
// West-edge feeder for the systolic MAC array.
// Buffers row-vectors in a small FIFO and issues them as wavefront-skewed
// in_w/inst_w lane streams, one extra cycle of delay per array row.
module west_edge_feeder #(
    parameter int ROW    = 8,
    parameter int BW     = 4,
    parameter int DEPTH  = 16,
    parameter int LEN_BW = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                wr,
    input  logic [ROW*BW-1:0]   in,
    output logic                full,
    output logic                empty,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_op,
    input  logic [LEN_BW-1:0]   cmd_len,
    output logic [ROW*BW-1:0]   out_w,
    output logic [ROW*2-1:0]    inst_w,
    output logic                busy,
    output logic                done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = (ROW > 1) ? $clog2(ROW) : 1;
    localparam logic [AW:0]       PTR_ONE = 1;
    localparam logic [LEN_BW-1:0] LEN_ONE = 1;

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

    state_t              state;
    logic                op_q;
    logic [LEN_BW-1:0]   rem_q;
    logic [CW-1:0]       cnt;

    logic [ROW*BW-1:0]   mem [DEPTH];
    logic [AW:0]         wptr;
    logic [AW:0]         rptr;
    logic                push;
    logic                pop;

    // Wavefront stage register: vector and instruction shared by all lanes
    logic [ROW*BW-1:0]   s_d;
    logic [1:0]          s_i;

    // Pointers carry a wrap bit so full and empty decode from registered state only
    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign push  = wr && !full;
    assign pop   = (state == ISSUE) && (rem_q != '0) && !empty;

    // FIFO storage; contents need no reset because the pointers gate visibility
    always_ff @(posedge clk) begin
        if (push)
            mem[wptr[AW-1:0]] <= in;
    end

    // FIFO pointers advance on accepted writes and on pops
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push)
                wptr <= wptr + PTR_ONE;
            if (pop)
                rptr <= rptr + PTR_ONE;
        end
    end

    // Burst sequencer with registered handshake and completion outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            op_q      <= 1'b0;
            rem_q     <= '0;
            cnt       <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        op_q      <= cmd_op;
                        rem_q     <= cmd_len;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (cmd_len == '0) begin
                            state <= DRAIN;
                            cnt   <= '0;
                            done  <= 1'b1;
                        end else begin
                            state <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (pop) begin
                        rem_q <= rem_q - LEN_ONE;
                        if (rem_q == LEN_ONE) begin
                            state <= DRAIN;
                            cnt   <= CW'(ROW - 1);
                            done  <= (ROW == 1);
                        end
                    end
                end
                DRAIN: begin
                    if (cnt == '0) begin
                        state     <= IDLE;
                        done      <= 1'b0;
                        cmd_ready <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        cnt  <= cnt - 1'b1;
                        done <= (cnt == CW'(1));
                    end
                end
                default: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    done      <= 1'b0;
                end
            endcase
        end
    end

    // Stage register loads the popped head, or a bubble on stall and drain
    always_ff @(posedge clk) begin
        if (reset) begin
            s_d <= '0;
            s_i <= 2'b00;
        end else if (pop) begin
            s_d <= mem[rptr[AW-1:0]];
            s_i <= op_q ? 2'b10 : 2'b01;
        end else begin
            s_d <= '0;
            s_i <= 2'b00;
        end
    end

    // Lane 0 is driven straight from the stage register
    assign out_w[BW-1:0] = s_d[BW-1:0];
    assign inst_w[1:0]   = s_i;

    for (genvar r = 1; r < ROW; r++) begin : g_lane
        logic [BW-1:0] pd [r];
        logic [1:0]    pi [r];

        // Lane r delay line of depth r builds the one-cycle-per-row skew
        always_ff @(posedge clk) begin
            if (reset) begin
                for (int k = 0; k < r; k++) begin
                    pd[k] <= '0;
                    pi[k] <= 2'b00;
                end
            end else begin
                pd[0] <= s_d[r*BW +: BW];
                pi[0] <= s_i;
                for (int k = 1; k < r; k++) begin
                    pd[k] <= pd[k-1];
                    pi[k] <= pi[k-1];
                end
            end
        end

        assign out_w[r*BW +: BW] = pd[r-1];
        assign inst_w[r*2 +: 2]  = pi[r-1];
    end

endmodule
